// File: rtl/execute_stage.sv
// Execute stage behind the register file: single-cycle ALU ops, iterative shift-add MUL,
// register-file write port and NZCV flag register.
module execute_stage #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MUL_STEPS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [WIDTH-1:0] imm,
  input  logic             use_imm,
  input  logic [3:0]       rd_in,
  output logic             out_valid,
  output logic             we_RF,
  output logic [3:0]       rd,
  output logic [WIDTH-1:0] WD3,
  output logic [3:0]       flags,
  output logic             illegal
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = $clog2(MUL_STEPS + 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_ORR = 4'd3;
  localparam logic [3:0] OP_EOR = 4'd4;
  localparam logic [3:0] OP_LSL = 4'd5;
  localparam logic [3:0] OP_LSR = 4'd6;
  localparam logic [3:0] OP_ASR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;
  localparam logic [3:0] OP_MOV = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             in_ready_nxt, out_valid_nxt, we_nxt, illegal_nxt;
  logic [3:0]       rd_nxt, flags_nxt, mul_rd, mul_rd_nxt;
  logic [WIDTH-1:0] wd3_nxt;
  logic [WIDTH-1:0] acc, acc_nxt, mcand, mcand_nxt, mplier, mplier_nxt;
  logic [CW-1:0]    count, count_nxt;

  logic [WIDTH-1:0] opb, diff, alu_res;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   amt;
  logic             alu_c, alu_v, alu_cv_upd, alu_we, alu_legal;

  assign opb  = use_imm ? imm : src_b;
  assign amt  = opb[SHW-1:0];
  assign sum  = {1'b0, src_a} + {1'b0, opb};
  assign diff = src_a - opb;

  // Single-cycle ALU on the live operands; its result is only used on an accepting edge.
  always_comb begin
    alu_res    = '0;
    alu_c      = 1'b0;
    alu_v      = 1'b0;
    alu_cv_upd = 1'b0;
    alu_we     = 1'b1;
    alu_legal  = 1'b1;
    case (op)
      OP_ADD: begin
        alu_res    = sum[WIDTH-1:0];
        alu_c      = sum[WIDTH];
        alu_v      = (src_a[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
        alu_cv_upd = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        alu_res    = diff;
        alu_c      = (src_a >= opb);
        alu_v      = (src_a[WIDTH-1] != opb[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);
        alu_cv_upd = 1'b1;
        alu_we     = (op != OP_CMP);
      end
      OP_AND:  alu_res = src_a & opb;
      OP_ORR:  alu_res = src_a | opb;
      OP_EOR:  alu_res = src_a ^ opb;
      OP_LSL:  alu_res = src_a << amt;
      OP_LSR:  alu_res = src_a >> amt;
      OP_ASR:  alu_res = WIDTH'($signed(src_a) >>> amt);
      OP_MOV:  alu_res = opb;
      OP_MUL:  alu_res = '0;
      default: begin
        alu_legal = 1'b0;
        alu_we    = 1'b0;
      end
    endcase
  end

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      we_RF     <= 1'b0;
      illegal   <= 1'b0;
      rd        <= '0;
      WD3       <= '0;
      flags     <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      count     <= '0;
      mul_rd    <= '0;
    end else begin
      state     <= state_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
      we_RF     <= we_nxt;
      illegal   <= illegal_nxt;
      rd        <= rd_nxt;
      WD3       <= wd3_nxt;
      flags     <= flags_nxt;
      acc       <= acc_nxt;
      mcand     <= mcand_nxt;
      mplier    <= mplier_nxt;
      count     <= count_nxt;
      mul_rd    <= mul_rd_nxt;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt     = state;
    in_ready_nxt  = in_ready;
    out_valid_nxt = 1'b0;
    we_nxt        = 1'b0;
    illegal_nxt   = 1'b0;
    rd_nxt        = rd;
    wd3_nxt       = WD3;
    flags_nxt     = flags;
    acc_nxt       = acc;
    mcand_nxt     = mcand;
    mplier_nxt    = mplier;
    count_nxt     = count;
    mul_rd_nxt    = mul_rd;
    case (state)
      S_IDLE, S_DONE: begin
        if (in_valid) begin
          if (op == OP_MUL) begin
            state_nxt    = S_MUL;
            in_ready_nxt = 1'b0;
            acc_nxt      = '0;
            mcand_nxt    = src_a;
            mplier_nxt   = opb;
            count_nxt    = '0;
            mul_rd_nxt   = rd_in;
          end else begin
            state_nxt     = S_DONE;
            in_ready_nxt  = 1'b1;
            out_valid_nxt = 1'b1;
            if (!alu_legal) begin
              illegal_nxt = 1'b1;
            end else begin
              flags_nxt[3] = alu_res[WIDTH-1];
              flags_nxt[2] = (alu_res == '0);
              if (alu_cv_upd) flags_nxt[1:0] = {alu_c, alu_v};
              if (alu_we) begin
                we_nxt  = 1'b1;
                rd_nxt  = rd_in;
                wd3_nxt = alu_res;
              end
            end
          end
        end else begin
          state_nxt    = S_IDLE;
          in_ready_nxt = 1'b1;
        end
      end
      S_MUL: begin
        // One multiplier bit per cycle, then one cycle to publish the product.
        if (count == CW'(MUL_STEPS)) begin
          state_nxt     = S_DONE;
          in_ready_nxt  = 1'b1;
          out_valid_nxt = 1'b1;
          we_nxt        = 1'b1;
          rd_nxt        = mul_rd;
          wd3_nxt       = acc;
          flags_nxt[3]  = acc[WIDTH-1];
          flags_nxt[2]  = (acc == '0);
        end else begin
          if (mplier[0]) acc_nxt = acc + mcand;
          mcand_nxt  = mcand << 1;
          mplier_nxt = mplier >> 1;
          count_nxt  = count + CW'(1);
        end
      end
      default: begin
        state_nxt    = S_IDLE;
        in_ready_nxt = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed vector table, hand-written
// back-to-back and mid-MUL reset sequences, and random traffic against a reference model.
module tb_execute_stage;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] src_a, src_b, imm;
  logic         use_imm;
  logic [3:0]   rd_in;
  logic         out_valid, we_RF, illegal;
  logic [3:0]   rd, flags;
  logic [W-1:0] WD3;

  int checks = 0;
  int errors = 0;
  logic [3:0] model_flags;

  execute_stage #(.WIDTH(W), .MUL_STEPS(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .src_a(src_a), .src_b(src_b), .imm(imm), .use_imm(use_imm), .rd_in(rd_in),
    .out_valid(out_valid), .we_RF(we_RF), .rd(rd), .WD3(WD3), .flags(flags),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, imm;
    bit          ui;
    logic [3:0]  rd;
    logic [31:0] wd3;
    logic [3:0]  fl;
    bit          we;
    bit          ill;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: instruction semantics computed with wide plain arithmetic.
  function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                inout logic [3:0] f, output logic [31:0] res,
                                output bit we, output bit ill);
    longint sa, sb, sr;
    logic [63:0] wide;
    bit arith;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    arith = 1'b0; we = 1'b1; ill = 1'b0; res = '0;
    case (o)
      4'd0: begin
        wide = {32'd0, a} + {32'd0, b};
        res = wide[31:0]; sr = sa + sb; arith = 1'b1;
        f[1] = (wide >= 64'h1_0000_0000);
        f[0] = (sr > 64'sh7FFF_FFFF) || (sr < -64'sh8000_0000);
      end
      4'd1, 4'd9: begin
        res = a - b; sr = sa - sb; arith = 1'b1;
        f[1] = (a >= b);
        f[0] = (sr > 64'sh7FFF_FFFF) || (sr < -64'sh8000_0000);
        we = (o == 4'd1);
      end
      4'd2: res = a & b;
      4'd3: res = a | b;
      4'd4: res = a ^ b;
      4'd5: begin wide = {32'd0, a} << b[4:0]; res = wide[31:0]; end
      4'd6: res = a / (32'd1 << b[4:0]);
      4'd7: begin sr = sa >>> b[4:0]; res = sr[31:0]; end
      4'd8: begin wide = {32'd0, a} * {32'd0, b}; res = wide[31:0]; end
      4'd10: res = b;
      default: begin we = 1'b0; ill = 1'b1; end
    endcase
    if (!ill) begin
      f[3] = res[31];
      f[2] = (res == 32'd0);
    end
    if (!arith) ; // C and V keep their previous values
  endfunction

  // Present one instruction, drop in_valid after acceptance, wait (bounded) for out_valid.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] i, input bit ui, input logic [3:0] r,
                       output int lat, output bit ready_low);
    op = o; src_a = a; src_b = b; imm = i; use_imm = ui; rd_in = r; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    src_a = $urandom; src_b = $urandom; imm = $urandom; rd_in = 4'($urandom);
    lat = 1; ready_low = 1'b1;
    while (!out_valid && lat < 40) begin
      if (in_ready) ready_low = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_out(input string tag, input int lat, input bit ready_low, input int exp_lat,
                           input logic [31:0] exp_wd3, input logic [3:0] exp_rd,
                           input logic [3:0] exp_fl, input bit exp_we, input bit exp_ill);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, " we_RF"}, 32'(we_RF), 32'(exp_we));
    chk({tag, " illegal"}, 32'(illegal), 32'(exp_ill));
    chk({tag, " flags"}, 32'(flags), 32'(exp_fl));
    if (exp_we) begin
      chk({tag, " rd"}, 32'(rd), 32'(exp_rd));
      chk({tag, " WD3"}, WD3, exp_wd3);
    end
    if (exp_lat > 1) chk({tag, " in_ready low during MUL"}, 32'(ready_low), 32'd1);
    @(negedge clk);
    chk({tag, " strobe ends"}, 32'(out_valid), 32'd0);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    bit rl;
    bit saw_wb;
    logic [31:0] eres;
    bit ewe, eill;
    logic [3:0] eop;
    logic [31:0] ea, eb, ei, bsel;
    bit eui;
    logic [3:0] erd;

    //        op     a             b             imm           ui rd     wd3           fl     we ill
    vecs[0]  = '{4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h0,        0, 4'd1,  32'h80000000, 4'b1001, 1, 0};
    vecs[1]  = '{4'd1,  32'h00000005, 32'h00000005, 32'h0,        0, 4'd2,  32'h00000000, 4'b0110, 1, 0};
    vecs[2]  = '{4'd8,  32'h0000FFFF, 32'h00010001, 32'h0,        0, 4'd3,  32'hFFFFFFFF, 4'b1010, 1, 0};
    vecs[3]  = '{4'd7,  32'h80000000, 32'h00000005, 32'd31,       1, 4'd4,  32'hFFFFFFFF, 4'b1010, 1, 0};
    vecs[4]  = '{4'd5,  32'h12345678, 32'h00000000, 32'h0,        0, 4'd5,  32'h12345678, 4'b0010, 1, 0};
    vecs[5]  = '{4'd6,  32'h80000000, 32'h00000004, 32'h0,        0, 4'd6,  32'h08000000, 4'b0010, 1, 0};
    vecs[6]  = '{4'd2,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        0, 4'd7,  32'h00F000F0, 4'b0010, 1, 0};
    vecs[7]  = '{4'd3,  32'h00000000, 32'h00000000, 32'h0,        0, 4'd8,  32'h00000000, 4'b0110, 1, 0};
    vecs[8]  = '{4'd4,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        0, 4'd9,  32'h00000000, 4'b0110, 1, 0};
    vecs[9]  = '{4'd10, 32'h00000000, 32'h00000007, 32'h80000001, 1, 4'd15, 32'h80000001, 4'b1010, 1, 0};
    vecs[10] = '{4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h0,        0, 4'd10, 32'h00000000, 4'b0110, 1, 0};
    vecs[11] = '{4'd1,  32'h80000000, 32'h00000001, 32'h0,        0, 4'd11, 32'h7FFFFFFF, 4'b0011, 1, 0};
    vecs[12] = '{4'd13, 32'h00000001, 32'h00000002, 32'h0,        0, 4'd12, 32'h00000000, 4'b0011, 0, 1};
    vecs[13] = '{4'd9,  32'h00000003, 32'h00000007, 32'h0,        0, 4'd13, 32'h00000000, 4'b1000, 0, 0};

    rst = 1'b0; in_valid = 1'b0; op = '0; src_a = '0; src_b = '0; imm = '0; use_imm = 1'b0; rd_in = '0;
    repeat (3) @(negedge clk);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset we_RF", 32'(we_RF), 32'd0);
    chk("reset rd", 32'(rd), 32'd0);
    chk("reset WD3", WD3, 32'd0);
    chk("reset flags", 32'(flags), 32'd0);
    chk("reset illegal", 32'(illegal), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Directed vector table.
    for (int k = 0; k < 14; k++) begin
      issue(vecs[k].op, vecs[k].a, vecs[k].b, vecs[k].imm, vecs[k].ui, vecs[k].rd, lat, rl);
      check_out($sformatf("vec%0d", k), lat, rl, (vecs[k].op == 4'd8) ? 34 : 1,
                vecs[k].wd3, vecs[k].rd, vecs[k].fl, vecs[k].we, vecs[k].ill);
    end

    // Back-to-back SUB then CMP with in_valid held.
    op = 4'd1; src_a = 32'd5; src_b = 32'd5; use_imm = 1'b0; rd_in = 4'd6; in_valid = 1'b1;
    @(negedge clk);
    chk("b2b sub out_valid", 32'(out_valid), 32'd1);
    chk("b2b sub we_RF", 32'(we_RF), 32'd1);
    chk("b2b sub WD3", WD3, 32'd0);
    chk("b2b sub flags", 32'(flags), 32'b0110);
    op = 4'd9; src_a = 32'd3; src_b = 32'd7; rd_in = 4'd14;
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b cmp out_valid", 32'(out_valid), 32'd1);
    chk("b2b cmp we_RF", 32'(we_RF), 32'd0);
    chk("b2b cmp flags", 32'(flags), 32'b1000);
    @(negedge clk);
    chk("b2b strobe ends", 32'(out_valid), 32'd0);

    // Asynchronous reset part way through a MUL.
    op = 4'd8; src_a = 32'h0000FFFF; src_b = 32'h00010001; use_imm = 1'b0; rd_in = 4'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort in_ready", 32'(in_ready), 32'd1);
    chk("abort we_RF", 32'(we_RF), 32'd0);
    chk("abort WD3", WD3, 32'd0);
    chk("abort flags", 32'(flags), 32'd0);
    chk("abort rd", 32'(rd), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    saw_wb = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (we_RF || out_valid) saw_wb = 1'b1;
    end
    chk("abort no writeback", 32'(saw_wb), 32'd0);
    issue(4'd0, 32'd2, 32'd2, 32'd0, 1'b0, 4'd1, lat, rl);
    check_out("add after abort", lat, rl, 1, 32'd4, 4'd1, 4'b0000, 1'b1, 1'b0);

    // Random traffic against the reference model.
    model_flags = 4'b0000;
    for (int n = 0; n < 300; n++) begin
      eop = ($urandom_range(0, 9) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
      if (eop == 4'd8 && $urandom_range(0, 1) == 0) eop = 4'd0;
      ea = rnd_val(); eb = rnd_val(); ei = rnd_val();
      eui = 1'($urandom_range(0, 1));
      erd = 4'($urandom);
      bsel = eui ? ei : eb;
      model(eop, ea, bsel, model_flags, eres, ewe, eill);
      issue(eop, ea, eb, ei, eui, erd, lat, rl);
      check_out($sformatf("rand%0d op%0d", n, eop), lat, rl, (eop == 4'd8) ? 34 : 1,
                eres, erd, model_flags, ewe, eill);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
